reorder_buffer: RTL

In-order-commit reorder buffer for the Tomasulo core.
- Issue allocates one entry per instruction and returns its 4-bit tag.
- The CDB marks entries ready with their results.
- The head entry commits one instruction per cycle by driving the register file's value-write port and its commit-side tag-clear port.
- A mispredicted branch at the head raises a one-cycle flush with the redirect PC.

---
 rtl/reorder_buffer_pkg.sv | 31 +++
 rtl/reorder_buffer_if.sv | 64 ++++++
 rtl/reorder_buffer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_buffer_pkg
//  Purpose  : Shared sizing constants, entry layout and the "no register"
//             encoding used by the ROB, issue unit, RS and LSB.
//  Revision : 1.0 - initial release
// ============================================================================
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int TAG_W     = $clog2(ROB_DEPTH);

    // Occupancy value meaning "every entry allocated"
    localparam logic [TAG_W:0] ROB_CNT_FULL = (TAG_W + 1)'(ROB_DEPTH);

    // Destination x0: the register file ignores writes to it
    localparam logic [4:0] NO_REG = 5'd0;

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic [4:0]  rd;
        logic        is_branch;
        logic        pred_taken;
        logic [31:0] value;
        logic        taken;
        logic [31:0] target;
    } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/reorder_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_buffer_if
//  Purpose  : Issue, CDB, operand-query, commit and flush signals of the ROB.
//             slave = the ROB itself, master = the surrounding core.
//  Revision : 1.0 - initial release
// ============================================================================
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    // Issue side
    logic              issue_valid;
    logic [4:0]        issue_rd;
    logic              issue_is_branch;
    logic              issue_pred_taken;
    logic [TAG_W-1:0]  issue_tag;
    logic              rob_full;
    logic              rob_empty;

    // Common data bus
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [31:0]       cdb_value;
    logic              cdb_taken;
    logic [31:0]       cdb_target;

    // Operand lookup
    logic [TAG_W-1:0]  query_tag_1;
    logic [TAG_W-1:0]  query_tag_2;
    logic              query_ready_1;
    logic              query_ready_2;
    logic [31:0]       query_val_1;
    logic [31:0]       query_val_2;

    // Commit / flush
    logic [4:0]        commit_reg;
    logic [31:0]       commit_val;
    logic [4:0]        commit_q_reg;
    logic [31:0]       commit_q_val;
    logic              flush_out;
    logic [31:0]       flush_pc;

    modport slave (
        input  issue_valid, issue_rd, issue_is_branch, issue_pred_taken,
        input  cdb_valid, cdb_tag, cdb_value, cdb_taken, cdb_target,
        input  query_tag_1, query_tag_2,
        output issue_tag, rob_full, rob_empty,
        output query_ready_1, query_ready_2, query_val_1, query_val_2,
        output commit_reg, commit_val, commit_q_reg, commit_q_val,
        output flush_out, flush_pc
    );

    modport master (
        output issue_valid, issue_rd, issue_is_branch, issue_pred_taken,
        output cdb_valid, cdb_tag, cdb_value, cdb_taken, cdb_target,
        output query_tag_1, query_tag_2,
        input  issue_tag, rob_full, rob_empty,
        input  query_ready_1, query_ready_2, query_val_1, query_val_2,
        input  commit_reg, commit_val, commit_q_reg, commit_q_val,
        input  flush_out, flush_pc
    );

endinterface
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_buffer
//  Purpose  : In-order-commit reorder buffer. Allocates a tag per issued
//             instruction, collects CDB results, retires the head entry one
//             per cycle and raises a one-cycle flush on branch mispredicts.
//  Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            rdy_in,
    reorder_buffer_if.slave bus
);

    rob_entry_t         r_entries [ROB_DEPTH];
    logic [TAG_W-1:0]   r_head;
    logic [TAG_W-1:0]   r_tail;
    logic [TAG_W:0]     r_count;

    logic [4:0]         r_commit_reg;
    logic [31:0]        r_commit_val;
    logic [4:0]         r_commit_q_reg;
    logic [31:0]        r_commit_q_val;
    logic               r_flush_out;
    logic [31:0]        r_flush_pc;

    rob_entry_t         w_head_entry;
    logic               w_full;
    logic               w_empty;
    logic               w_issue;
    logic               w_commit;
    logic               w_mispredict;
    logic               w_cdb_hit;

    assign w_head_entry = r_entries[r_head];
    assign w_full       = (r_count == ROB_CNT_FULL);
    assign w_empty      = (r_count == '0);

    // Nothing enters or leaves during the flush cycle; its effects are wiped
    assign w_issue      = bus.issue_valid & ~w_full & ~r_flush_out;
    assign w_commit     = w_head_entry.busy & w_head_entry.ready & ~r_flush_out;
    assign w_mispredict = w_commit & w_head_entry.is_branch
                        & (w_head_entry.taken != w_head_entry.pred_taken);
    assign w_cdb_hit    = bus.cdb_valid & r_entries[bus.cdb_tag].busy;

    assign bus.issue_tag    = r_tail;
    assign bus.rob_full     = w_full;
    assign bus.rob_empty    = w_empty;
    assign bus.commit_reg   = r_commit_reg;
    assign bus.commit_val   = r_commit_val;
    assign bus.commit_q_reg = r_commit_q_reg;
    assign bus.commit_q_val = r_commit_q_val;
    assign bus.flush_out    = r_flush_out;
    assign bus.flush_pc     = r_flush_pc;

    // Operand lookup, with same-cycle forwarding from the CDB
    always_comb begin
        bus.query_ready_1 = r_entries[bus.query_tag_1].ready;
        bus.query_val_1   = r_entries[bus.query_tag_1].value;
        bus.query_ready_2 = r_entries[bus.query_tag_2].ready;
        bus.query_val_2   = r_entries[bus.query_tag_2].value;
        if (bus.cdb_valid && (bus.cdb_tag == bus.query_tag_1)) begin
            bus.query_ready_1 = 1'b1;
            bus.query_val_1   = bus.cdb_value;
        end
        if (bus.cdb_valid && (bus.cdb_tag == bus.query_tag_2)) begin
            bus.query_ready_2 = 1'b1;
            bus.query_val_2   = bus.cdb_value;
        end
    end

    // Entry array, pointers and registered commit/flush outputs
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_reg   <= NO_REG;
            r_commit_val   <= '0;
            r_commit_q_reg <= NO_REG;
            r_commit_q_val <= '0;
            r_flush_out    <= 1'b0;
            r_flush_pc     <= '0;
        end else if (rdy_in) begin
            if (r_flush_out) begin
                // Squash every in-flight entry after the mispredicted branch
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    r_entries[i] <= '0;
                end
                r_head         <= '0;
                r_tail         <= '0;
                r_count        <= '0;
                r_commit_reg   <= NO_REG;
                r_commit_val   <= '0;
                r_commit_q_reg <= NO_REG;
                r_commit_q_val <= '0;
                r_flush_out    <= 1'b0;
                r_flush_pc     <= '0;
            end else begin
                // Commit outputs are single-cycle pulses; x0 means "no write"
                r_commit_reg   <= NO_REG;
                r_commit_val   <= '0;
                r_commit_q_reg <= NO_REG;
                r_commit_q_val <= '0;
                r_flush_out    <= 1'b0;
                r_flush_pc     <= '0;

                if (w_cdb_hit) begin
                    r_entries[bus.cdb_tag].ready  <= 1'b1;
                    r_entries[bus.cdb_tag].value  <= bus.cdb_value;
                    r_entries[bus.cdb_tag].taken  <= bus.cdb_taken;
                    r_entries[bus.cdb_tag].target <= bus.cdb_target;
                end

                if (w_commit) begin
                    r_commit_reg              <= w_head_entry.rd;
                    r_commit_val              <= w_head_entry.value;
                    r_commit_q_reg            <= w_head_entry.rd;
                    r_commit_q_val            <= {{(32 - TAG_W){1'b0}}, r_head};
                    r_entries[r_head].busy    <= 1'b0;
                    r_entries[r_head].ready   <= 1'b0;
                    r_head                    <= r_head + 1'b1;
                    if (w_mispredict) begin
                        r_flush_out <= 1'b1;
                        r_flush_pc  <= w_head_entry.target;
                    end
                end

                // Tail slot is never busy when issue is allowed, so this
                // cannot collide with the CDB or commit updates above
                if (w_issue) begin
                    r_entries[r_tail] <= '{busy:       1'b1,
                                           ready:      1'b0,
                                           rd:         bus.issue_rd,
                                           is_branch:  bus.issue_is_branch,
                                           pred_taken: bus.issue_pred_taken,
                                           value:      32'd0,
                                           taken:      1'b0,
                                           target:     32'd0};
                    r_tail <= r_tail + 1'b1;
                end

                unique case ({w_issue, w_commit})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
